// File: rtl/ram_dump_ctrl_pkg.sv
// Shared types and constants for the RAM block debug read-out path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_dump_ctrl_pkg;

    localparam int IADR_W = 8;   // instruction RAM: 256 x 8
    localparam int DADR_W = 5;   // data RAM: 32 x 8

    localparam logic SEL_IRAM = 1'b0;
    localparam logic SEL_DRAM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } dump_state_t;

endpackage

// File: rtl/ram_dump_ctrl_if.sv
// Byte stream from the dump controller to the UART transmit formatter.
// Latency: n/a (wires only).
// Backpressure: valid/ready; the byte transfers when tx_valid && tx_ready.
// Ports: tx_data (byte), tx_valid (master -> slave), tx_ready (slave -> master).
interface ram_dump_ctrl_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/ram_dump_ctrl_rd_lat_cnt.sv
// Down-counter timing the RAM read latency; load has priority, stops at zero.
// Latency: cnt_zero reflects the counter register (no combinational path from load).
// Backpressure: none.
// Ports: clk, rst, load, load_val -> cnt_zero.
module ram_dump_ctrl_rd_lat_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         cnt_zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/ram_dump_ctrl.sv
// Walks an inclusive IRAM/DRAM address range and streams each byte to the UART formatter.
// Latency: SETUP + RD_LAT wait cycles to first tx_valid; RD_LAT + 2 cycles per byte when tx_ready stays high.
// Backpressure: holds tx_valid/tx_data stable in SEND until tx_ready; abort is honoured after the pending handshake.
// Ports: clk, rst; dump_start/sel/sadr/eadr/abort command; i_/d_ram read address+data; dump_running; tx (master); dump_done.
module ram_dump_ctrl
    import ram_dump_ctrl_pkg::*;
#(
    parameter int IADR_W = ram_dump_ctrl_pkg::IADR_W,
    parameter int DADR_W = ram_dump_ctrl_pkg::DADR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_start,
    input  logic              dump_sel,
    input  logic [7:0]        dump_sadr,
    input  logic [7:0]        dump_eadr,
    input  logic              dump_abort,
    output logic [IADR_W-1:0] i_ram_radr,
    input  logic [7:0]        i_ram_rdata,
    output logic [DADR_W-1:0] d_ram_radr,
    input  logic [7:0]        d_ram_rdata,
    output logic              dump_running,
    ram_dump_ctrl_if.master   tx,
    output logic              dump_done
);

    localparam int LAT_W = 2;

    dump_state_t       state_q, state_nxt;
    logic              sel_q;
    logic [IADR_W-1:0] cur_q, end_q, cur_inc;
    logic [DADR_W-1:0] d_inc;
    logic [7:0]        tx_data_q;
    logic [7:0]        rd_data;
    logic              lat_zero, lat_load;
    logic              tx_valid_c;

    // DRAM addresses wrap within DADR_W bits; the upper bits of cur_q stay zero.
    assign d_inc   = cur_q[DADR_W-1:0] + DADR_W'(1);
    assign cur_inc = (sel_q == SEL_DRAM) ? IADR_W'(d_inc) : cur_q + IADR_W'(1);
    assign rd_data = (sel_q == SEL_DRAM) ? d_ram_rdata : i_ram_rdata;

    // Reload on every entry into WAIT so each byte gets a full RD_LAT window.
    assign lat_load = (state_nxt == ST_WAIT) && (state_q != ST_WAIT);

    ram_dump_ctrl_rd_lat_cnt #(.W(LAT_W)) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (lat_load),
        .load_val (LAT_W'(RD_LAT - 1)),
        .cnt_zero (lat_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (dump_start) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = dump_abort ? ST_DONE : ST_WAIT;
            ST_WAIT: begin
                if (dump_abort)    state_nxt = ST_DONE;
                else if (lat_zero) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                // Abort never withdraws tx_valid; it only picks DONE over NEXT at the handshake.
                if (tx.tx_ready) begin
                    state_nxt = (dump_abort || (cur_q == end_q)) ? ST_DONE : ST_NEXT;
                end
            end
            ST_NEXT:  state_nxt = dump_abort ? ST_DONE : ST_WAIT;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dump_running = 1'b0;
        dump_done    = 1'b0;
        tx_valid_c   = 1'b0;
        i_ram_radr   = '0;
        d_ram_radr   = '0;
        case (state_q)
            ST_SETUP, ST_WAIT, ST_SEND, ST_NEXT: begin
                dump_running = 1'b1;
                if (sel_q == SEL_DRAM) d_ram_radr = cur_q[DADR_W-1:0];
                else                   i_ram_radr = cur_q;
                tx_valid_c = (state_q == ST_SEND);
            end
            ST_DONE: dump_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= SEL_IRAM;
            cur_q     <= '0;
            end_q     <= '0;
            tx_data_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && dump_start) begin
                sel_q <= dump_sel;
                if (dump_sel == SEL_DRAM) begin
                    cur_q <= IADR_W'(dump_sadr[DADR_W-1:0]);
                    end_q <= IADR_W'(dump_eadr[DADR_W-1:0]);
                end else begin
                    cur_q <= dump_sadr[IADR_W-1:0];
                    end_q <= dump_eadr[IADR_W-1:0];
                end
            end
            if ((state_q == ST_WAIT) && lat_zero) begin
                tx_data_q <= rd_data;
            end
            if ((state_q == ST_SEND) && (state_nxt == ST_NEXT)) begin
                cur_q <= cur_inc;
            end
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_c;

endmodule

// File: tb/tb_ram_dump_ctrl.sv
module tb_ram_dump_ctrl;

    typedef struct {
        logic            sel;
        logic [7:0]      sadr;
        logic [7:0]      eadr;
        int              n;
        logic [3:0][7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dump_start = 1'b0;
    logic       dump_sel = 1'b0;
    logic [7:0] dump_sadr = 8'h00;
    logic [7:0] dump_eadr = 8'h00;
    logic       dump_abort = 1'b0;
    logic [7:0] i_ram_radr;
    logic [7:0] i_rdata = 8'h00;
    logic [4:0] d_ram_radr;
    logic [7:0] d_rdata = 8'h00;
    logic       dump_running;
    logic       dump_done;

    ram_dump_ctrl_if tx_if();

    ram_dump_ctrl #(.IADR_W(8), .DADR_W(5), .RD_LAT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .dump_start   (dump_start),
        .dump_sel     (dump_sel),
        .dump_sadr    (dump_sadr),
        .dump_eadr    (dump_eadr),
        .dump_abort   (dump_abort),
        .i_ram_radr   (i_ram_radr),
        .i_ram_rdata  (i_rdata),
        .d_ram_radr   (d_ram_radr),
        .d_ram_rdata  (d_rdata),
        .dump_running (dump_running),
        .tx           (tx_if),
        .dump_done    (dump_done)
    );

    always #5 clk = ~clk;

    logic [7:0] iram [256];
    logic [7:0] dram [32];

    // Synchronous-read RAM models, one cycle of latency.
    always @(posedge clk) begin
        i_rdata <= iram[i_ram_radr];
        d_rdata <= dram[d_ram_radr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got_q [$];
    int         stamp_q [$];
    int         done_cnt = 0;
    int         viol = 0;
    int         stall_cnt = 0;
    logic       mon_sel = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                got_q.push_back(tx_if.tx_data);
                stamp_q.push_back(cyc);
            end
            if (tx_if.tx_valid && !tx_if.tx_ready) stall_cnt++;
            if (dump_done) done_cnt++;
            if (tx_if.tx_valid && !dump_running) viol++;
            if (dump_done && dump_running) viol++;
            if (prev_stall && (!tx_if.tx_valid || tx_if.tx_data != prev_data)) viol++;
            if (dump_running && mon_sel && i_ram_radr != 8'h00) viol++;
            if (dump_running && !mon_sel && d_ram_radr != 5'h00) viol++;
            prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
            prev_data  = tx_if.tx_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk_vec(input logic s, input logic [7:0] sa, input logic [7:0] ea,
                                    input int n, input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [7:0] b3);
        vec_t v;
        v.sel  = s;
        v.sadr = sa;
        v.eadr = ea;
        v.n    = n;
        v.exp  = {b3, b2, b1, b0};
        return v;
    endfunction

    task automatic clear_mon();
        got_q.delete();
        stamp_q.delete();
        viol = 0;
        stall_cnt = 0;
    endtask

    // Returns during the SETUP cycle, with start_cyc = that cycle's number.
    task automatic pulse_start(input logic s, input logic [7:0] sa, input logic [7:0] ea,
                               output int start_cyc);
        @(posedge clk);
        #1;
        dump_start = 1'b1;
        dump_sel   = s;
        dump_sadr  = sa;
        dump_eadr  = ea;
        @(posedge clk);
        #1;
        dump_start = 1'b0;
        start_cyc  = cyc;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int k = 0;
        while (done_cnt == d0 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, " done_seen"}, done_cnt != d0, 1);
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int k = 0;
        while (got_q.size() < n && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, " bytes_reached"}, got_q.size() >= n, 1);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!tx_if.tx_valid && k < 100);
        chk({tag, " valid_seen"}, tx_if.tx_valid, 1);
    endtask

    task automatic check_dump(input string tag, input int n, input logic [3:0][7:0] exp,
                              input int start_cyc, input bit timed, input int d0);
        chk({tag, " count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), got_q[i], exp[i]);
        if (timed && stamp_q.size() > 0) begin
            chk({tag, " first_latency"}, stamp_q[0] - start_cyc, 2);
            for (int i = 1; i < stamp_q.size(); i++)
                chk($sformatf("%s interval%0d", tag, i), stamp_q[i] - stamp_q[i-1], 3);
        end
        chk({tag, " protocol_viol"}, viol, 0);
        chk({tag, " done_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int sc;
        int d0;
        clear_mon();
        mon_sel = v.sel;
        d0 = done_cnt;
        pulse_start(v.sel, v.sadr, v.eadr, sc);
        chk({tag, " running_in_setup"}, dump_running, 1);
        wait_done(d0, tag);
        check_dump(tag, v.n, v.exp, sc, 1'b1, d0);
        @(negedge clk);
        chk({tag, " idle_after_done"}, {dump_running, dump_done, tx_if.tx_valid}, 3'b000);
    endtask

    vec_t vecs [5];

    initial begin
        int sc;
        int d0;
        int dummy;

        for (int a = 0; a < 256; a++) iram[a] = 8'(a) ^ 8'h5A;
        for (int a = 0; a < 32; a++)  dram[a] = 8'hC0 | 8'(a);

        vecs[0] = mk_vec(1'b0, 8'h10, 8'h13, 4, 8'h4A, 8'h4B, 8'h48, 8'h49);
        vecs[1] = mk_vec(1'b1, 8'h3E, 8'h21, 4, 8'hDE, 8'hDF, 8'hC0, 8'hC1);
        vecs[2] = mk_vec(1'b0, 8'h07, 8'h07, 1, 8'h5D, 8'h00, 8'h00, 8'h00);
        vecs[3] = mk_vec(1'b0, 8'hFE, 8'h01, 4, 8'hA4, 8'hA5, 8'h5A, 8'h5B);
        vecs[4] = mk_vec(1'b1, 8'h1F, 8'h1F, 1, 8'hDF, 8'h00, 8'h00, 8'h00);

        tx_if.tx_ready = 1'b1;

        // Reset state
        #3;
        chk("reset running", dump_running, 0);
        chk("reset tx_valid", tx_if.tx_valid, 0);
        chk("reset done", dump_done, 0);
        chk("reset tx_data", tx_if.tx_data, 0);
        chk("reset i_radr", i_ram_radr, 0);
        chk("reset d_radr", d_ram_radr, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: second byte stalled for 5 cycles
        clear_mon();
        mon_sel = 1'b0;
        d0 = done_cnt;
        pulse_start(1'b0, 8'h40, 8'h43, sc);
        wait_bytes(1, "bp");
        @(posedge clk);
        #1;
        tx_if.tx_ready = 1'b0;
        wait_valid("bp");
        repeat (5) @(posedge clk);
        #1;
        tx_if.tx_ready = 1'b1;
        wait_done(d0, "bp");
        check_dump("bp", 4, {8'h19, 8'h18, 8'h1B, 8'h1A}, sc, 1'b0, d0);
        chk("bp stall_cycles", stall_cnt, 5);

        // Abort while byte 2 of an 8-byte dump is pending
        clear_mon();
        d0 = done_cnt;
        pulse_start(1'b0, 8'h20, 8'h27, sc);
        wait_bytes(1, "abort");
        @(posedge clk);
        #1;
        tx_if.tx_ready = 1'b0;
        wait_valid("abort");
        @(posedge clk);
        #1;
        dump_abort = 1'b1;
        @(posedge clk);
        #1;
        tx_if.tx_ready = 1'b1;
        wait_done(d0, "abort");
        dump_abort = 1'b0;
        check_dump("abort", 2, {8'h00, 8'h00, 8'h7B, 8'h7A}, sc, 1'b0, d0);

        // Start re-pulsed mid-dump is ignored
        clear_mon();
        d0 = done_cnt;
        pulse_start(1'b0, 8'h10, 8'h13, sc);
        wait_bytes(1, "restart");
        pulse_start(1'b1, 8'h00, 8'h05, dummy);
        wait_done(d0, "restart");
        check_dump("restart", 4, {8'h49, 8'h48, 8'h4B, 8'h4A}, sc, 1'b1, d0);
        repeat (10) @(negedge clk);
        chk("restart no_second_dump", got_q.size(), 4);
        chk("restart running_low", dump_running, 0);

        // Asynchronous reset during WAIT
        clear_mon();
        d0 = done_cnt;
        pulse_start(1'b0, 8'h50, 8'h57, sc);
        @(posedge clk);
        #1;
        chk("rst precond running", dump_running, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst async outputs",
            {dump_running, dump_done, tx_if.tx_valid, tx_if.tx_data, i_ram_radr, d_ram_radr},
            32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("rst no_done", done_cnt - d0, 0);
        chk("rst no_bytes", got_q.size(), 0);
        run_vec(vecs[0], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time limit reached, required completion");
        $fatal(1);
    end

endmodule
